// File: rtl/ordering_pkg.sv
// Shared constants, output-slot type and rotate-priority pick for the ordering ID allocator.
package ordering_pkg;
  localparam int NUM_ID    = 8;
  localparam int ID_W      = $clog2(NUM_ID);
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [PAYLOAD_W-1:0] payload;
    logic                 order;
  } ord_req_t;

  // First set bit of vec at or after ptr, wrapping; 0 when vec is empty.
  // Scanning from the farthest offset down lets the nearest one win.
  function automatic logic [ID_W-1:0] pick_first(input logic [NUM_ID-1:0] vec,
                                                 input logic [ID_W-1:0] ptr);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] sel;
    sel = '0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (vec[idx]) sel = idx;
    end
    return sel;
  endfunction
endpackage

// File: rtl/ordering_id_alloc_if.sv
// Request / tagged-RX / free / status bundle of the ordering ID allocator.
interface ordering_id_alloc_if;
  import ordering_pkg::*;
  logic                 req_valid_i;
  logic [PAYLOAD_W-1:0] req_payload_i;
  logic                 req_order_i;
  logic                 req_ready_o;
  logic                 rx_valid_o;
  logic [ID_W-1:0]      rx_id_o;
  logic [PAYLOAD_W-1:0] rx_payload_o;
  logic                 rx_order_o;
  logic                 rx_ready_i;
  logic                 free_i;
  logic [ID_W-1:0]      free_id_i;
  logic [ID_W:0]        inflight_o;
  logic                 err_o;

  modport master (
    output req_valid_i, req_payload_i, req_order_i, rx_ready_i, free_i, free_id_i,
    input  req_ready_o, rx_valid_o, rx_id_o, rx_payload_o, rx_order_o, inflight_o, err_o
  );
  modport slave (
    input  req_valid_i, req_payload_i, req_order_i, rx_ready_i, free_i, free_id_i,
    output req_ready_o, rx_valid_o, rx_id_o, rx_payload_o, rx_order_o, inflight_o, err_o
  );
endinterface

// File: rtl/ordering_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, one-hot and encoded.
module ordering_rr_pick
  import ordering_pkg::*;
(
  input  logic [NUM_ID-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic [NUM_ID-1:0] gnt,
  output logic [ID_W-1:0]   idx,
  output logic              any
);
  always_comb begin
    any = |req;
    idx = pick_first(req, ptr);
    gnt = '0;
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/ordering_id_alloc.sv
// Free-list ID allocator feeding the ordering RX port through a one-entry output slot.
// Optional ORDERING_ID_ALLOC_CHK_EN builds the sticky double-free / in-slot-free error check.
module ordering_id_alloc
  import ordering_pkg::*;
(
  input logic               clk,
  input logic               reset,
  ordering_id_alloc_if.slave bus
);
  logic [NUM_ID-1:0] busy_q, busy_d, gnt;
  logic [ID_W-1:0]   ptr_q, pick_idx;
  logic [ID_W:0]     cnt_q;
  logic              rx_valid_q, any_free, slot_free, accept, free_hit;
  ord_req_t          slot_q;

  ordering_rr_pick u_pick (
    .req (~busy_q),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (pick_idx),
    .any (any_free)
  );

  assign slot_free   = ~rx_valid_q | bus.rx_ready_i;
  assign bus.req_ready_o = slot_free & any_free;
  assign accept      = bus.req_valid_i & bus.req_ready_o;
  assign free_hit    = bus.free_i & busy_q[bus.free_id_i];

  // Picker sees busy_q, so an ID freed this cycle can never be the one granted.
  always_comb begin
    busy_d = busy_q;
    if (free_hit) busy_d[bus.free_id_i] = 1'b0;
    if (accept)   busy_d = busy_d | gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rx_valid_q <= 1'b0;
      slot_q     <= '0;
    end else begin
      busy_q <= busy_d;
      case ({accept, free_hit})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (accept) begin
        ptr_q      <= pick_idx + 1'b1;
        rx_valid_q <= 1'b1;
        slot_q     <= '{id: pick_idx, payload: bus.req_payload_i, order: bus.req_order_i};
      end else if (bus.rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

`ifdef ORDERING_ID_ALLOC_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (bus.free_i & (~busy_q[bus.free_id_i] |
             (rx_valid_q & ~bus.rx_ready_i & (slot_q.id == bus.free_id_i))))
      err_q <= 1'b1;
  end
  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.rx_valid_o   = rx_valid_q;
  assign bus.rx_id_o      = slot_q.id;
  assign bus.rx_payload_o = slot_q.payload;
  assign bus.rx_order_o   = slot_q.order;
  assign bus.inflight_o   = cnt_q;
endmodule

// File: tb/tb_ordering_id_alloc.sv
// Directed bench for ordering_id_alloc: allocation order, free/realloc, stall, wrap, same-cycle free, error flag.
module tb_ordering_id_alloc;
  import ordering_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  ordering_id_alloc_if bus ();
  ordering_id_alloc dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i = 1'b0; bus.req_payload_i = '0; bus.req_order_i = 1'b0;
    bus.rx_ready_i = 1'b1; bus.free_i = 1'b0; bus.free_id_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (bus.rx_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", bus.rx_valid_o); end
    checks++; if (bus.rx_id_o !== 3'd0 || bus.rx_payload_o !== 16'h0 || bus.rx_order_o !== 1'b0) begin
      failures++; $display("FAIL reset_slot got id=%0d pl=%h ord=%0b exp 0/0/0", bus.rx_id_o, bus.rx_payload_o, bus.rx_order_o); end
    checks++; if (bus.inflight_o !== 4'd0) begin failures++; $display("FAIL reset_inflight got=%0d exp=0", bus.inflight_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err_o); end
    checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", bus.req_ready_o); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      bus.req_valid_i = 1'b1; bus.req_payload_i = 16'h0100 + 16'(i); bus.req_order_i = i[0];
      #1;
      checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%0b exp=1", i, bus.req_ready_o); end
      step();
      checks++; if (bus.rx_valid_o !== 1'b1 || bus.rx_id_o !== 3'(i) || bus.rx_payload_o !== 16'h0100 + 16'(i) || bus.rx_order_o !== i[0]) begin
        failures++; $display("FAIL fill_out[%0d] got v=%0b id=%0d pl=%h ord=%0b exp v=1 id=%0d pl=%h ord=%0b",
                             i, bus.rx_valid_o, bus.rx_id_o, bus.rx_payload_o, bus.rx_order_o, i, 16'h0100 + 16'(i), i[0]); end
    end
    #1;
    checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("FAIL full_req_ready got=%0b exp=0", bus.req_ready_o); end
    checks++; if (bus.inflight_o !== 4'd8) begin failures++; $display("FAIL full_inflight got=%0d exp=8", bus.inflight_o); end
    step();
    bus.req_valid_i = 1'b0;
    checks++; if (bus.rx_valid_o !== 1'b0 || bus.inflight_o !== 4'd8) begin
      failures++; $display("FAIL full_drain got v=%0b inflight=%0d exp v=0 inflight=8", bus.rx_valid_o, bus.inflight_o); end
  endtask

  task automatic test_free_realloc();
    bus.free_i = 1'b1; bus.free_id_i = 3'd5; bus.req_valid_i = 1'b1; bus.req_payload_i = 16'h0555;
    #1;
    checks++; if (bus.req_ready_o !== 1'b0) begin failures++; $display("FAIL free_same_cycle_ready got=%0b exp=0", bus.req_ready_o); end
    step();
    bus.free_i = 1'b0;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1 || bus.inflight_o !== 4'd7) begin
      failures++; $display("FAIL after_free got ready=%0b inflight=%0d exp 1/7", bus.req_ready_o, bus.inflight_o); end
    step();
    bus.req_valid_i = 1'b0;
    checks++; if (bus.rx_valid_o !== 1'b1 || bus.rx_id_o !== 3'd5 || bus.inflight_o !== 4'd8) begin
      failures++; $display("FAIL realloc got v=%0b id=%0d inflight=%0d exp 1/5/8", bus.rx_valid_o, bus.rx_id_o, bus.inflight_o); end
    step();
    // Release everything; ptr is left at 6.
    for (int i = 0; i < 8; i++) begin
      bus.free_i = 1'b1; bus.free_id_i = 3'(i);
      step();
    end
    bus.free_i = 1'b0;
    checks++; if (bus.inflight_o !== 4'd0) begin failures++; $display("FAIL free_all_inflight got=%0d exp=0", bus.inflight_o); end
  endtask

  task automatic test_stall();
    bus.rx_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.req_payload_i = 16'hBEEF; bus.req_order_i = 1'b1;
    step();
    bus.req_payload_i = 16'h1234; bus.req_order_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.rx_valid_o !== 1'b1 || bus.rx_id_o !== 3'd6 || bus.rx_payload_o !== 16'hBEEF ||
                    bus.rx_order_o !== 1'b1 || bus.req_ready_o !== 1'b0) begin
        failures++; $display("FAIL stall[%0d] got v=%0b id=%0d pl=%h ord=%0b rdy=%0b exp 1/6/beef/1/0",
                             c, bus.rx_valid_o, bus.rx_id_o, bus.rx_payload_o, bus.rx_order_o, bus.req_ready_o); end
      step();
    end
    bus.rx_ready_i = 1'b1; bus.req_payload_i = 16'hCAFE;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin failures++; $display("FAIL drain_ready got=%0b exp=1", bus.req_ready_o); end
    step();
    bus.req_valid_i = 1'b0;
    checks++; if (bus.rx_valid_o !== 1'b1 || bus.rx_id_o !== 3'd7 || bus.rx_payload_o !== 16'hCAFE || bus.inflight_o !== 4'd2) begin
      failures++; $display("FAIL drain_reload got v=%0b id=%0d pl=%h inflight=%0d exp 1/7/cafe/2",
                           bus.rx_valid_o, bus.rx_id_o, bus.rx_payload_o, bus.inflight_o); end
    step();
    bus.free_i = 1'b1; bus.free_id_i = 3'd6; step();
    bus.free_id_i = 3'd7; step();
    bus.free_i = 1'b0;
  endtask

  task automatic test_wrap();
    logic [2:0] exp_ids [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.req_valid_i = 1'b0;
    bus.free_i = 1'b1; bus.free_id_i = 3'd1;
    step();
    bus.free_i = 1'b0;
    bus.req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_payload_i = 16'h0A00 + 16'(i);
      step();
      checks++; if (bus.rx_valid_o !== 1'b1 || bus.rx_id_o !== exp_ids[i]) begin
        failures++; $display("FAIL wrap[%0d] got v=%0b id=%0d exp v=1 id=%0d", i, bus.rx_valid_o, bus.rx_id_o, exp_ids[i]); end
    end
    bus.req_valid_i = 1'b0;
    checks++; if (bus.inflight_o !== 4'd8) begin failures++; $display("FAIL wrap_inflight got=%0d exp=8", bus.inflight_o); end
  endtask

  task automatic test_same_cycle();
    bus.free_i = 1'b1; bus.free_id_i = 3'd0;
    step();
    bus.free_i = 1'b1; bus.free_id_i = 3'd2; bus.req_valid_i = 1'b1;
    #1;
    checks++; if (bus.inflight_o !== 4'd7) begin failures++; $display("FAIL same_pre_inflight got=%0d exp=7", bus.inflight_o); end
    step();
    bus.free_i = 1'b0; bus.req_valid_i = 1'b0;
    checks++; if (bus.rx_id_o !== 3'd0 || bus.inflight_o !== 4'd7) begin
      failures++; $display("FAIL same_cycle got id=%0d inflight=%0d exp 0/7", bus.rx_id_o, bus.inflight_o); end
    bus.req_valid_i = 1'b1;
    step();
    bus.req_valid_i = 1'b0;
    checks++; if (bus.rx_id_o !== 3'd2 || bus.inflight_o !== 4'd8) begin
      failures++; $display("FAIL same_next got id=%0d inflight=%0d exp 2/8", bus.rx_id_o, bus.inflight_o); end
    step();
  endtask

  task automatic test_err();
    logic exp_err;
`ifdef ORDERING_ID_ALLOC_CHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    bus.free_i = 1'b1; bus.free_id_i = 3'd6;
    step();
    checks++; if (bus.err_o !== 1'b0 || bus.inflight_o !== 4'd7) begin
      failures++; $display("FAIL legal_free got err=%0b inflight=%0d exp 0/7", bus.err_o, bus.inflight_o); end
    step();
    bus.free_i = 1'b0;
    checks++; if (bus.err_o !== exp_err || bus.inflight_o !== 4'd7) begin
      failures++; $display("FAIL double_free got err=%0b inflight=%0d exp %0b/7", bus.err_o, bus.inflight_o, exp_err); end
    step(); step();
    checks++; if (bus.err_o !== exp_err) begin failures++; $display("FAIL err_sticky got=%0b exp=%0b", bus.err_o, exp_err); end
    bus.req_valid_i = 1'b1; bus.rx_ready_i = 1'b0;
    step();
    reset = 1'b1; bus.req_valid_i = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checks++; if (bus.err_o !== 1'b0 || bus.inflight_o !== 4'd0 || bus.rx_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      failures++; $display("FAIL mid_reset got err=%0b inflight=%0d v=%0b rdy=%0b exp 0/0/0/1",
                           bus.err_o, bus.inflight_o, bus.rx_valid_o, bus.req_ready_o); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_free_realloc();
    test_stall();
    test_wrap();
    test_same_cycle();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
